// File: rtl/dmem_access_unit.sv
// Data-memory access sequencer: forms EA = Target + Offset and runs load, store
// and read-modify-write inc/dec against a synchronous-read data memory.
module dmem_access_unit #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          ReqValid,
  output logic          ReqReady,
  input  logic [1:0]    Op,
  input  logic [AW-1:0] Target,
  input  logic [AW-1:0] Offset,
  input  logic [DW-1:0] WrData,
  output logic          RespValid,
  output logic [DW-1:0] RespData,
  output logic          Zero,
  output logic [AW-1:0] DmAddr,
  output logic          DmWrEn,
  output logic [DW-1:0] DmWrData,
  input  logic [DW-1:0] DmRdData
);

  localparam logic [1:0]    OP_LOAD  = 2'b00;
  localparam logic [1:0]    OP_STORE = 2'b01;
  localparam logic [1:0]    OP_INC   = 2'b10;
  localparam logic [1:0]    OP_DEC   = 2'b11;
  localparam logic [DW-1:0] ONE      = {{(DW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t        state_r;
  state_t        next_s;
  logic          accept_s;
  logic [AW-1:0] ea_s;
  logic [AW-1:0] ea_r;
  logic [1:0]    op_r;
  logic [DW-1:0] data_r;

  // Handshake and next-state selection; RESP accepts back-to-back without a bubble.
  always_comb begin
    ReqReady = Reset && ((state_r == S_IDLE) || (state_r == S_RESP));
    accept_s = ReqValid && ReqReady;
    ea_s     = Target + Offset;
    next_s   = state_r;
    case (state_r)
      S_IDLE, S_RESP: begin
        if (accept_s) begin
          next_s = (Op == OP_STORE) ? S_WR : S_RD;
        end else begin
          next_s = S_IDLE;
        end
      end
      S_RD:    next_s = S_CAP;
      S_CAP:   next_s = (op_r == OP_LOAD) ? S_RESP : S_WR;
      S_WR:    next_s = S_RESP;
      default: next_s = S_IDLE;
    endcase
  end

  // State, latched request and the data register (read value or RMW result).
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r <= S_IDLE;
      ea_r    <= {AW{1'b0}};
      op_r    <= OP_LOAD;
      data_r  <= {DW{1'b0}};
    end else begin
      state_r <= next_s;
      if (accept_s) begin
        ea_r   <= ea_s;
        op_r   <= Op;
        data_r <= WrData;
      end else if (state_r == S_CAP) begin
        case (op_r)
          OP_INC:  data_r <= DmRdData + ONE;
          OP_DEC:  data_r <= DmRdData - ONE;
          default: data_r <= DmRdData;
        endcase
      end else begin
        data_r <= data_r;
      end
    end
  end

  // Outputs decode only registered state, so reset clears them (and aborts a write) at once.
  always_comb begin
    RespValid = 1'b0;
    RespData  = {DW{1'b0}};
    Zero      = 1'b0;
    DmAddr    = {AW{1'b0}};
    DmWrEn    = 1'b0;
    DmWrData  = {DW{1'b0}};
    case (state_r)
      S_RD: begin
        DmAddr = ea_r;
      end
      S_WR: begin
        DmAddr   = ea_r;
        DmWrEn   = 1'b1;
        DmWrData = data_r;
      end
      S_RESP: begin
        RespValid = 1'b1;
        if (op_r != OP_STORE) begin
          RespData = data_r;
          Zero     = (data_r == {DW{1'b0}});
        end else begin
          RespData = {DW{1'b0}};
          Zero     = 1'b0;
        end
      end
      default: begin
        RespValid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit with a behavioural synchronous-read memory.
`timescale 1ns/1ps
module tb_dmem_access_unit;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       ReqValid;
  logic       ReqReady;
  logic [1:0] Op;
  logic [7:0] Target;
  logic [7:0] Offset;
  logic [7:0] WrData;
  logic       RespValid;
  logic [7:0] RespData;
  logic       Zero;
  logic [7:0] DmAddr;
  logic       DmWrEn;
  logic [7:0] DmWrData;
  logic [7:0] DmRdData;

  logic [7:0] mem [0:255];
  logic       pl_en;
  logic [7:0] pl_addr;
  logic [7:0] pl_data;
  int         wr_cnt = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         wr_before;

  dmem_access_unit #(.AW(8), .DW(8)) dut (
    .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .Op(Op), .Target(Target), .Offset(Offset), .WrData(WrData),
    .RespValid(RespValid), .RespData(RespData), .Zero(Zero),
    .DmAddr(DmAddr), .DmWrEn(DmWrEn), .DmWrData(DmWrData), .DmRdData(DmRdData)
  );

  always #5 Clk = ~Clk;

  // Memory model: preload port has priority; read data appears the cycle after the address.
  always @(posedge Clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (DmWrEn) mem[DmAddr] <= DmWrData;
    if (DmWrEn) wr_cnt <= wr_cnt + 1;
    DmRdData <= mem[DmAddr];
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge Clk);
    pl_en = 1'b0;
  endtask

  task automatic drive_req(input logic [1:0] op, input logic [7:0] t, input logic [7:0] o,
                           input logic [7:0] wd);
    ReqValid = 1'b1; Op = op; Target = t; Offset = o; WrData = wd;
  endtask

  task automatic idle_inputs();
    ReqValid = 1'b0; Op = 2'b00; Target = 8'h00; Offset = 8'h00; WrData = 8'h00;
  endtask

  initial begin
    Reset = 1'b0; pl_en = 1'b0; pl_addr = 8'h00; pl_data = 8'h00;
    idle_inputs();
    for (int i = 0; i < 256; i++) begin
      @(negedge Clk);
      pl_en = 1'b1; pl_addr = 8'(i); pl_data = 8'h00;
    end
    @(negedge Clk);
    pl_en = 1'b0;
    // Reset state
    chk1("rst_ready", ReqReady, 1'b0);
    chk1("rst_resp", RespValid, 1'b0);
    chk1("rst_wren", DmWrEn, 1'b0);
    chk8("rst_addr", DmAddr, 8'h00);
    chk8("rst_rdata", RespData, 8'h00);
    Reset = 1'b1;
    preload(8'd35, 8'h5A);

    // Load: EA 30+5=35, response at T0+3
    wr_before = wr_cnt;
    drive_req(2'b00, 8'd30, 8'd5, 8'hEE);
    chk1("idle_ready", ReqReady, 1'b1);
    @(negedge Clk); idle_inputs();
    chk8("ld_rd_addr", DmAddr, 8'd35);
    chk1("ld_rd_ready", ReqReady, 1'b0);
    chk1("ld_rd_resp", RespValid, 1'b0);
    @(negedge Clk);
    chk1("ld_cap_resp", RespValid, 1'b0);
    @(negedge Clk);
    chk1("ld_resp_valid", RespValid, 1'b1);
    chk8("ld_resp_data", RespData, 8'h5A);
    chk1("ld_resp_zero", Zero, 1'b0);
    @(negedge Clk);
    chk1("ld_idle_resp", RespValid, 1'b0);
    chk8("ld_idle_addr", DmAddr, 8'h00);
    chk_int("ld_no_write", wr_cnt, wr_before);

    // Store with address wrap: 200+60 -> 4, response at T0+2
    drive_req(2'b01, 8'd200, 8'd60, 8'hC3);
    @(negedge Clk); idle_inputs();
    chk1("st_wren", DmWrEn, 1'b1);
    chk8("st_addr", DmAddr, 8'd4);
    chk8("st_wdata", DmWrData, 8'hC3);
    chk1("st_wr_resp", RespValid, 1'b0);
    @(negedge Clk);
    chk1("st_resp_valid", RespValid, 1'b1);
    chk8("st_resp_data", RespData, 8'h00);
    chk1("st_resp_zero", Zero, 1'b0);
    chk1("st_resp_wren", DmWrEn, 1'b0);
    chk8("st_mem", mem[4], 8'hC3);
    @(negedge Clk);

    // Decrement 1 -> 0, then 0 -> 255
    preload(8'd200, 8'd1);
    for (int k = 0; k < 2; k++) begin
      drive_req(2'b11, 8'd190, 8'd10, 8'h55);
      @(negedge Clk); idle_inputs();
      chk8("dec_rd_addr", DmAddr, 8'd200);
      chk1("dec_rd_wren", DmWrEn, 1'b0);
      @(negedge Clk);
      chk1("dec_cap_resp", RespValid, 1'b0);
      @(negedge Clk);
      chk1("dec_wr_wren", DmWrEn, 1'b1);
      chk8("dec_wr_data", DmWrData, (k == 0) ? 8'h00 : 8'hFF);
      chk1("dec_wr_resp", RespValid, 1'b0);
      @(negedge Clk);
      chk1("dec_resp_valid", RespValid, 1'b1);
      chk8("dec_resp_data", RespData, (k == 0) ? 8'h00 : 8'hFF);
      chk1("dec_resp_zero", Zero, (k == 0) ? 1'b1 : 1'b0);
      chk8("dec_mem", mem[200], (k == 0) ? 8'h00 : 8'hFF);
      @(negedge Clk);
    end

    // Increment wrap 255 -> 0; ReqReady low in RD/CAP/WR, high in RESP
    preload(8'd180, 8'hFF);
    wr_before = wr_cnt;
    drive_req(2'b10, 8'd180, 8'd0, 8'h00);
    @(negedge Clk); idle_inputs();
    chk1("inc_rd_ready", ReqReady, 1'b0);
    @(negedge Clk);
    chk1("inc_cap_ready", ReqReady, 1'b0);
    @(negedge Clk);
    chk1("inc_wr_ready", ReqReady, 1'b0);
    chk8("inc_wr_data", DmWrData, 8'h00);
    @(negedge Clk);
    chk1("inc_resp_ready", ReqReady, 1'b1);
    chk1("inc_resp_valid", RespValid, 1'b1);
    chk8("inc_resp_data", RespData, 8'h00);
    chk1("inc_resp_zero", Zero, 1'b1);
    chk8("inc_mem", mem[180], 8'h00);
    chk_int("inc_one_write", wr_cnt, wr_before + 1);
    @(negedge Clk);

    // Back-to-back: store then load to address 50 with ReqValid held
    drive_req(2'b01, 8'd50, 8'd0, 8'h77);
    @(negedge Clk);
    chk1("b2b_st_wren", DmWrEn, 1'b1);
    drive_req(2'b00, 8'd40, 8'd10, 8'h00);
    @(negedge Clk);
    chk1("b2b_st_resp", RespValid, 1'b1);
    chk1("b2b_st_ready", ReqReady, 1'b1);
    @(negedge Clk); idle_inputs();
    chk8("b2b_ld_rd_addr", DmAddr, 8'd50);
    chk1("b2b_ld_rd_resp", RespValid, 1'b0);
    @(negedge Clk);
    @(negedge Clk);
    chk1("b2b_ld_resp", RespValid, 1'b1);
    chk8("b2b_ld_data", RespData, 8'h77);
    @(negedge Clk);

    // Reset during CAP of an increment: no write, no response
    preload(8'd90, 8'h10);
    wr_before = wr_cnt;
    drive_req(2'b10, 8'd90, 8'd0, 8'h00);
    @(negedge Clk); idle_inputs();
    @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    chk1("rcap_wren", DmWrEn, 1'b0);
    chk1("rcap_ready", ReqReady, 1'b0);
    chk8("rcap_addr", DmAddr, 8'h00);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      chk1("rcap_no_resp", RespValid, 1'b0);
    end
    chk8("rcap_mem", mem[90], 8'h10);
    chk_int("rcap_no_write", wr_cnt, wr_before);
    Reset = 1'b1;

    // First request after release completes with normal RMW latency
    drive_req(2'b10, 8'd90, 8'd0, 8'h00);
    @(negedge Clk); idle_inputs();
    chk1("post_rd_resp", RespValid, 1'b0);
    @(negedge Clk);
    chk1("post_cap_resp", RespValid, 1'b0);
    @(negedge Clk);
    chk1("post_wr_resp", RespValid, 1'b0);
    @(negedge Clk);
    chk1("post_resp_valid", RespValid, 1'b1);
    chk8("post_resp_data", RespData, 8'h11);
    chk8("post_mem", mem[90], 8'h11);
    @(negedge Clk);

    // Reset during WR: write enable drops asynchronously, write aborted
    wr_before = wr_cnt;
    drive_req(2'b11, 8'd90, 8'd0, 8'h00);
    @(negedge Clk); idle_inputs();
    @(negedge Clk);
    @(negedge Clk);
    chk1("rwr_wren_before", DmWrEn, 1'b1);
    #1 Reset = 1'b0;
    #1;
    chk1("rwr_wren_after", DmWrEn, 1'b0);
    chk8("rwr_wdata", DmWrData, 8'h00);
    @(negedge Clk);
    chk1("rwr_no_resp", RespValid, 1'b0);
    @(negedge Clk);
    chk8("rwr_mem", mem[90], 8'h11);
    chk_int("rwr_no_write", wr_cnt, wr_before);
    Reset = 1'b1;
    @(negedge Clk);
    chk1("rwr_idle_ready", ReqReady, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
